// File: rtl/stack_pkg.sv
// Shared constants, command encoding and priority decode for the operand stack.
// Bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
package stack_pkg;
    localparam int STACK_DATA_W = 8;
    localparam int STACK_DEPTH  = 16;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_TOS,
        CMD_POP,
        CMD_PUSH,
        CMD_REPLACE
    } stack_cmd_e;

    // push outranks pop, pop outranks tos; push+pop collapses into replace-top
    function automatic stack_cmd_e stack_decode(input logic tos, input logic pop, input logic push);
        if (push && pop) return CMD_REPLACE;
        if (push)        return CMD_PUSH;
        if (pop)         return CMD_POP;
        if (tos)         return CMD_TOS;
        return CMD_NONE;
    endfunction
endpackage

// File: rtl/stack_ram.sv
// Stack storage: synchronous write, asynchronous read at an arbitrary index.
module stack_ram
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [DATA_W-1:0]        rd_data_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[wr_idx_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU: pointer, flags and registered top-of-stack.
// Define STACK_BOUNDS_CHECK_EN to block overflow/underflow and raise a sticky err.
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tos,
    input  logic              pop,
    input  logic              push,
    input  logic              MtoS,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

    logic [AW:0]       sp_q, sp_d, sp_inc, sp_dec;
    logic [DATA_W-1:0] dout_q, dout_d, din, top;
    logic [AW-1:0]     top_idx, wr_idx;
    logic              we, push_like;
    stack_cmd_e        cmd;

    assign din     = MtoS ? mem_data : alu_res;
    assign cmd     = stack_decode(tos, pop, push);
    assign sp_inc  = sp_q + SP_ONE;
    assign sp_dec  = sp_q - SP_ONE;
    // sp-1 truncated to the address width: an empty stack reads entry DEPTH-1
    assign top_idx = sp_dec[AW-1:0];
    assign full    = (sp_q == SP_FULL);
    assign empty   = (sp_q == '0);

    // replace-top on an empty stack has nothing to replace
    assign push_like = (cmd == CMD_PUSH) || (cmd == CMD_REPLACE && empty);

`ifdef STACK_BOUNDS_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        we     = 1'b0;
        wr_idx = sp_q[AW-1:0];
`ifdef STACK_BOUNDS_CHECK_EN
        err_d  = err_q;
`endif
        if (cmd == CMD_REPLACE && !empty) begin
            we     = 1'b1;
            wr_idx = top_idx;
            dout_d = top;
        end else if (push_like) begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (full) begin
                err_d = 1'b1;
            end else begin
                we   = 1'b1;
                sp_d = sp_inc;
            end
`else
            we   = 1'b1;
            sp_d = full ? '0 : sp_inc;
`endif
        end else if (cmd == CMD_POP || cmd == CMD_TOS) begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (empty) begin
                err_d = 1'b1;
            end else begin
                dout_d = top;
                if (cmd == CMD_POP) sp_d = sp_dec;
            end
`else
            dout_d = top;
            if (cmd == CMD_POP) sp_d = empty ? SP_FULL : sp_dec;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q   <= '0;
            dout_q <= '0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
        end
    end

`ifdef STACK_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // reset wins over a same-cycle push, so the write is gated too
    stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk       (clk),
        .we_i      (we & rst),
        .wr_idx_i  (wr_idx),
        .wr_data_i (din),
        .rd_idx_i  (top_idx),
        .rd_data_o (top)
    );

    assign dout = dout_q;
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with a behavioural stack model and a dout scoreboard.
module tb_stack_unit;
    localparam int DP = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tos = 1'b0, pop = 1'b0, push = 1'b0, MtoS = 1'b0;
    logic [7:0] mem_data = 8'h00, alu_res = 8'h00;
    logic [7:0] dout;
    logic       full, empty, err;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_mem [DP];
    int         m_sp   = 0;
    logic [7:0] m_dout = 8'h00;
    logic       m_err  = 1'b0;

    stack_unit #(.DATA_W(8), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .tos(tos), .pop(pop), .push(push), .MtoS(MtoS),
        .mem_data(mem_data), .alu_res(alu_res),
        .dout(dout), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: drive at negedge, advance the model, check #1 after posedge
    task automatic cyc(input logic r, input logic t, input logic p, input logic u,
                       input logic ms, input logic [7:0] md, input logic [7:0] ar);
        logic [7:0] din;
        logic       rd;
        @(negedge clk);
        rst = r; tos = t; pop = p; push = u; MtoS = ms; mem_data = md; alu_res = ar;
        din = ms ? md : ar;
        rd  = 1'b0;
        if (!r) begin
            m_sp = 0; m_dout = 8'h00; m_err = 1'b0;
        end else if (u && p && m_sp != 0) begin
            m_dout = m_mem[m_sp-1];
            m_mem[m_sp-1] = din;
            rd = 1'b1;
        end else if (u) begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (m_sp == DP) m_err = 1'b1;
            else begin m_mem[m_sp] = din; m_sp++; end
`else
            m_mem[m_sp % DP] = din;
            m_sp = (m_sp == DP) ? 0 : m_sp + 1;
`endif
        end else if (p || t) begin
`ifdef STACK_BOUNDS_CHECK_EN
            if (m_sp == 0) m_err = 1'b1;
            else begin
                m_dout = m_mem[m_sp-1]; rd = 1'b1;
                if (p) m_sp--;
            end
`else
            m_dout = m_mem[(m_sp + DP - 1) % DP]; rd = 1'b1;
            if (p) m_sp = (m_sp == 0) ? DP : m_sp - 1;
`endif
        end
        if (rd) exp_q.push_back(m_dout);
        @(posedge clk);
        #1;
        if (rd && exp_q.size() > 0) chk("sb_dout", dout, exp_q.pop_front());
        chk("dout_hold", dout, m_dout);
        chk("empty", {7'd0, empty}, {7'd0, m_sp == 0});
        chk("full",  {7'd0, full},  {7'd0, m_sp == DP});
        chk("err",   {7'd0, err},   {7'd0, m_err});
    endtask

    task automatic idle();              cyc(1, 0, 0, 0, 0, 8'h00, 8'h00); endtask
    task automatic rst_cyc();           cyc(0, 0, 0, 0, 0, 8'h00, 8'h00); endtask
    task automatic push_alu(input logic [7:0] v); cyc(1, 0, 0, 1, 0, 8'h5A, v); endtask
    task automatic push_mem(input logic [7:0] v); cyc(1, 0, 0, 1, 1, v, 8'hA5); endtask
    task automatic do_tos();            cyc(1, 1, 0, 0, 0, 8'h00, 8'h00); endtask
    task automatic do_pop();            cyc(1, 0, 1, 0, 0, 8'h00, 8'h00); endtask

    initial begin
        // reset and idle
        rst_cyc();
        chk("rst_dout", dout, 8'h00);
        chk("rst_empty", {7'd0, empty}, 8'h01);
        chk("rst_full", {7'd0, full}, 8'h00);
        chk("rst_err", {7'd0, err}, 8'h00);
        idle();

        // source select and LIFO order
        push_alu(8'h12);
        push_mem(8'h34);
        do_tos();
        chk("tos_34", dout, 8'h34);
        do_pop();
        chk("pop_34", dout, 8'h34);
        do_pop();
        chk("pop_12", dout, 8'h12);
        chk("pop_empty", {7'd0, empty}, 8'h01);

        // replace-top
        push_alu(8'h05);
        push_alu(8'h07);
        cyc(1, 0, 1, 1, 0, 8'h00, 8'h0C);
        chk("repl_old", dout, 8'h07);
        do_tos();
        chk("repl_new", dout, 8'h0C);
        cyc(1, 1, 0, 1, 0, 8'h00, 8'h0D);   // tos+push behaves as push, dout holds
        chk("tospush_hold", dout, 8'h0C);
        do_pop();
        chk("tospush_top", dout, 8'h0D);
        do_pop();
        do_pop();
        chk("drain_empty", {7'd0, empty}, 8'h01);

        // fill to full then overflow
        for (int i = 0; i < DP; i++) push_alu(8'(i));
        chk("fill_full", {7'd0, full}, 8'h01);
        push_alu(8'hAA);
`ifdef STACK_BOUNDS_CHECK_EN
        chk("ovf_err", {7'd0, err}, 8'h01);
        do_tos();
        chk("ovf_tos", dout, 8'h0F);
`else
        chk("wrap_empty", {7'd0, empty}, 8'h01);
        chk("wrap_err", {7'd0, err}, 8'h00);
`endif

        // underflow
        rst_cyc();
        do_pop();
`ifdef STACK_BOUNDS_CHECK_EN
        chk("udf_dout", dout, 8'h00);
        chk("udf_err", {7'd0, err}, 8'h01);
        idle();
        chk("udf_sticky", {7'd0, err}, 8'h01);
`else
        chk("udf_wrap_dout", dout, 8'h0F);
        chk("udf_wrap_full", {7'd0, full}, 8'h01);
`endif
        rst_cyc();
        chk("err_clr", {7'd0, err}, 8'h00);

        // reset beats a concurrent push
        push_alu(8'h21);
        push_alu(8'h22);
        push_alu(8'h23);
        cyc(0, 0, 0, 1, 0, 8'h00, 8'h24);
        chk("rstpush_empty", {7'd0, empty}, 8'h01);
        chk("rstpush_dout", dout, 8'h00);
        push_mem(8'h55);
        do_pop();
        chk("post_rst_pop", dout, 8'h55);
        chk("post_rst_empty", {7'd0, empty}, 8'h01);

        chk("sb_drain", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
